result_requant_collector: RTL and testbench

- Sits directly downstream of the last weight computation cell in the systolic chain.
- Captures each flagged accumulator result from the chain's result bus, then requantizes it to a DATA_WIDTH output activation using fixed multiply, shift, offset and saturation.
- Tags each activation with its neuron index and a last-of-frame flag, then buffers it in a FIFO.
- Results are drained through a valid/ready handshake to the next layer feeder or host readout.

---
 rtl/result_requant_collector.sv | 191 +++++++++++++++++++
 tb/tb_result_requant_collector.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/result_requant_collector.sv
`default_nettype none
// ============================================================================
// Module   : result_requant_collector
// Purpose  : Collects flagged accumulator results from the end of the systolic
//            chain, requantizes them (multiply, floor shift, offset, saturate)
//            to DATA_WIDTH activations, tags each with its neuron index and a
//            last-of-frame flag, and buffers them in a FIFO drained through a
//            valid/ready handshake.
// Ports    : clk          - clock, rising edge
//            rst          - asynchronous active-high reset
//            input_result - {valid, accumulator[RESULT_WIDTH-1:0]}
//            out_value    - requantized activation at FIFO head
//            out_index    - neuron index of head entry
//            out_last     - head entry is neuron NEURON_COUNT-1
//            out_valid    - FIFO non-empty
//            out_ready    - consumer accepts head when out_valid && out_ready
//            fifo_count   - current FIFO occupancy
//            overflow     - sticky: a result was dropped on a full FIFO
// Notes    : NEURON_COUNT in 1..2**INDEX_WIDTH; FIFO_DEPTH a power of 2, >= 2.
// Revision : 1.0 - initial release
// ============================================================================
module result_requant_collector #(
  parameter int          DATA_WIDTH    = 8,
  parameter int          RESULT_WIDTH  = 16,
  parameter int          INDEX_WIDTH   = 10,
  parameter int          NEURON_COUNT  = 4,
  parameter int unsigned MULTIPLIER    = 1,
  parameter int          MULT_WIDTH    = 16,
  parameter int          SHIFT         = 0,
  parameter int unsigned OUTPUT_OFFSET = 0,
  parameter int          FIFO_DEPTH    = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [RESULT_WIDTH:0]         input_result,
  output logic [DATA_WIDTH-1:0]         out_value,
  output logic [INDEX_WIDTH-1:0]        out_index,
  output logic                          out_last,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int c_prod_w = RESULT_WIDTH + MULT_WIDTH;
  localparam int c_sum_w  = c_prod_w + 1;
  localparam int c_addr_w = $clog2(FIFO_DEPTH);
  localparam int c_ptr_w  = c_addr_w + 1;

  localparam logic [MULT_WIDTH-1:0]  c_mult     = MULT_WIDTH'(MULTIPLIER);
  localparam logic [c_sum_w-1:0]     c_offset   = c_sum_w'(OUTPUT_OFFSET);
  localparam logic [c_sum_w-1:0]     c_sat_max  = c_sum_w'({DATA_WIDTH{1'b1}});
  localparam logic [INDEX_WIDTH-1:0] c_last_idx = INDEX_WIDTH'(NEURON_COUNT - 1);
  localparam logic [c_ptr_w-1:0]     c_depth    = c_ptr_w'(FIFO_DEPTH);

  // --------------------------------------------------------------------------
  // Stage 1: capture, full-width multiply, neuron tagging
  // --------------------------------------------------------------------------
  logic                   w_in_valid;
  logic [c_prod_w-1:0]    w_prod;
  logic [INDEX_WIDTH-1:0] r_neuron_cnt;
  logic                   r_s1_valid;
  logic [c_prod_w-1:0]    r_s1_prod;
  logic [INDEX_WIDTH-1:0] r_s1_tag;
  logic                   r_s1_last;

  assign w_in_valid = input_result[RESULT_WIDTH];
  assign w_prod     = c_prod_w'(input_result[RESULT_WIDTH-1:0]) * c_prod_w'(c_mult);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_neuron_cnt <= '0;
      r_s1_valid   <= 1'b0;
      r_s1_prod    <= '0;
      r_s1_tag     <= '0;
      r_s1_last    <= 1'b0;
    end else begin
      r_s1_valid <= w_in_valid;
      if (w_in_valid) begin
        r_s1_prod    <= w_prod;
        r_s1_tag     <= r_neuron_cnt;
        r_s1_last    <= (r_neuron_cnt == c_last_idx);
        r_neuron_cnt <= (r_neuron_cnt == c_last_idx) ? '0 : r_neuron_cnt + 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stage 2: floor shift, offset (one bit of headroom), saturate
  // --------------------------------------------------------------------------
  logic [c_prod_w-1:0]    w_shifted;
  logic [c_sum_w-1:0]     w_sum;
  logic [DATA_WIDTH-1:0]  w_sat;
  logic                   r_s2_valid;
  logic [DATA_WIDTH-1:0]  r_s2_value;
  logic [INDEX_WIDTH-1:0] r_s2_tag;
  logic                   r_s2_last;

  assign w_shifted = r_s1_prod >> SHIFT;
  assign w_sum     = c_sum_w'(w_shifted) + c_offset;
  assign w_sat     = (w_sum > c_sat_max) ? {DATA_WIDTH{1'b1}} : w_sum[DATA_WIDTH-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_s2_value <= '0;
      r_s2_tag   <= '0;
      r_s2_last  <= 1'b0;
    end else begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_value <= w_sat;
        r_s2_tag   <= r_s1_tag;
        r_s2_last  <= r_s1_last;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output FIFO: extra pointer MSB separates full from empty
  // --------------------------------------------------------------------------
  localparam int c_entry_w = DATA_WIDTH + INDEX_WIDTH + 1;

  logic [c_entry_w-1:0]   r_mem [FIFO_DEPTH];
  logic [c_ptr_w-1:0]     r_wr_ptr;
  logic [c_ptr_w-1:0]     r_rd_ptr;
  logic [c_ptr_w-1:0]     w_count;
  logic [c_ptr_w-1:0]     w_rd_next;
  logic [c_ptr_w-1:0]     w_remaining;
  logic                   w_empty;
  logic                   w_full;
  logic                   w_pop;
  logic                   w_push;
  logic [c_entry_w-1:0]   w_wr_entry;
  logic [DATA_WIDTH-1:0]  r_head_value;
  logic [INDEX_WIDTH-1:0] r_head_index;
  logic                   r_head_last;
  logic                   r_overflow;

  assign w_count     = r_wr_ptr - r_rd_ptr;
  assign w_empty     = (w_count == '0);
  assign w_full      = (w_count == c_depth);
  assign w_pop       = !w_empty && out_ready;
  // A full FIFO still accepts the write when the head leaves on the same edge.
  assign w_push      = r_s2_valid && (!w_full || w_pop);
  assign w_rd_next   = r_rd_ptr + c_ptr_w'(w_pop);
  // Entries still stored after this edge's pop, not counting this edge's push.
  assign w_remaining = w_count - c_ptr_w'(w_pop);
  assign w_wr_entry  = {r_s2_value, r_s2_tag, r_s2_last};

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[c_addr_w-1:0]] <= w_wr_entry;
    end
  end

  // The head is kept in its own registers so the outputs hold their last
  // value when the FIFO runs empty instead of exposing stale storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_head_value <= '0;
      r_head_index <= '0;
      r_head_last  <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_rd_ptr <= w_rd_next;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_remaining != '0) begin
        {r_head_value, r_head_index, r_head_last} <= r_mem[w_rd_next[c_addr_w-1:0]];
      end else if (w_push) begin
        {r_head_value, r_head_index, r_head_last} <= w_wr_entry;
      end
      if (r_s2_valid && w_full && !w_pop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign out_value  = r_head_value;
  assign out_index  = r_head_index;
  assign out_last   = r_head_last;
  assign out_valid  = !w_empty;
  assign fifo_count = w_count;
  assign overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_result_requant_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_result_requant_collector
// Purpose  : Self-checking bench for result_requant_collector. Two instances
//            (default scaling and MULT=3/SHIFT=2/OFFSET=5) share stimulus and
//            are compared every cycle against a queue-level reference model,
//            plus directed literal checks for the key scenarios.
// Revision : 1.0 - initial release
// ============================================================================
module tb_result_requant_collector;

  localparam int NC    = 4;
  localparam int DEPTH = 8;

  typedef struct {
    int value;
    int index;
    bit last;
  } ent_t;

  logic        clk;
  logic        rst;
  logic [16:0] input_result;
  logic        out_ready;

  logic [7:0]  v0, v1;
  logic [9:0]  i0, i1;
  logic        l0, l1, vld0, vld1, ovf0, ovf1;
  logic [3:0]  c0, c1;

  int checks   = 0;
  int failures = 0;

  result_requant_collector u_dut0 (
    .clk(clk), .rst(rst), .input_result(input_result),
    .out_value(v0), .out_index(i0), .out_last(l0), .out_valid(vld0),
    .out_ready(out_ready), .fifo_count(c0), .overflow(ovf0)
  );

  result_requant_collector #(
    .MULTIPLIER(3), .SHIFT(2), .OUTPUT_OFFSET(5)
  ) u_dut1 (
    .clk(clk), .rst(rst), .input_result(input_result),
    .out_value(v1), .out_index(i1), .out_last(l1), .out_valid(vld1),
    .out_ready(out_ready), .fifo_count(c1), .overflow(ovf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int requant(input int d, input longint acc);
    longint m, sh, off, s;
    m   = (d == 0) ? 1 : 3;
    sh  = (d == 0) ? 0 : 2;
    off = (d == 0) ? 0 : 5;
    s   = ((acc * m) >> sh) + off;
    return (s > 255) ? 255 : int'(s);
  endfunction

  ent_t mfifo [2][16];
  int   mhead [2];
  int   mcnt  [2];
  ent_t mhold [2];
  bit   movf  [2];
  int   mneur [2];
  bit   mdv   [2][2];
  ent_t mde   [2][2];

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      mhead[d] = 0; mcnt[d] = 0; movf[d] = 0; mneur[d] = 0;
      mhold[d] = '{0, 0, 1'b0};
      for (int s = 0; s < 2; s++) begin
        mdv[d][s] = 1'b0;
        mde[d][s] = '{0, 0, 1'b0};
      end
    end
  endtask

  // One clock edge: a result accepted now reaches the FIFO two edges later.
  task automatic model_step(input int d);
    ent_t cand, e;
    bit   cv, pop, full;
    cv   = mdv[d][1];
    cand = mde[d][1];
    mdv[d][1] = mdv[d][0];
    mde[d][1] = mde[d][0];
    if (input_result[16]) begin
      e.value = requant(d, longint'(input_result[15:0]));
      e.index = mneur[d];
      e.last  = (mneur[d] == NC - 1);
      mdv[d][0] = 1'b1;
      mde[d][0] = e;
      mneur[d]  = (mneur[d] + 1) % NC;
    end else begin
      mdv[d][0] = 1'b0;
    end
    full = (mcnt[d] == DEPTH);
    pop  = (mcnt[d] > 0) && out_ready;
    if (pop) begin
      mhead[d] = (mhead[d] + 1) % 16;
      mcnt[d]--;
    end
    if (cv) begin
      if (!full || pop) begin
        mfifo[d][(mhead[d] + mcnt[d]) % 16] = cand;
        mcnt[d]++;
      end else begin
        movf[d] = 1'b1;
      end
    end
    if (mcnt[d] > 0) mhold[d] = mfifo[d][mhead[d]];
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else for (int d = 0; d < 2; d++) model_step(d);
  end

  task automatic cmp(input int d, input logic [7:0] v, input logic [9:0] ix, input logic l,
                     input logic vld, input logic [3:0] cnt, input logic ovf);
    chk($sformatf("d%0d out_valid", d), vld, (mcnt[d] > 0));
    chk($sformatf("d%0d fifo_count", d), cnt, mcnt[d]);
    chk($sformatf("d%0d overflow", d), ovf, movf[d]);
    chk($sformatf("d%0d out_value", d), v, mhold[d].value);
    chk($sformatf("d%0d out_index", d), ix, mhold[d].index);
    chk($sformatf("d%0d out_last", d), l, mhold[d].last);
  endtask

  always @(negedge clk) begin
    cmp(0, v0, i0, l0, vld0, c0, ovf0);
    cmp(1, v1, i1, l1, vld1, c1, ovf1);
  end

  // ---------------- stimulus ----------------
  task automatic reset_pulse();
    @(negedge clk); #1 rst = 1'b1;
    input_result = '0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
  endtask

  int lit_in0 [4] = '{100, 7, 255, 3};
  int lit_d1a [4] = '{80, 10, 196, 7};
  int lit_in1 [4] = '{40, 1000, 16'h1F00, 41};
  int lit_d0b [4] = '{40, 255, 255, 41};
  int lit_d1b [4] = '{35, 255, 255, 35};

  // Feed four results back-to-back with out_ready=1 and check the heads.
  task automatic directed4(input int ins[4], input int e0[4], input int e1[4]);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      input_result = (k < 4) ? {1'b1, 16'(ins[k])} : {1'b0, 16'hBEEF};
      if (k == 1 || k == 2) chk("latency out_valid", vld0, 0);
      if (k >= 3 && k <= 6) begin
        chk("dir d0 value", v0, e0[k-3]);
        chk("dir d1 value", v1, e1[k-3]);
        chk("dir index", i0, k - 3);
        chk("dir last", l0, (k == 6));
        chk("dir valid", vld0, 1);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    input_result = '0;
    out_ready = 1'b0;

    chk("model 41", requant(1, 41), 35);
    chk("model 40", requant(1, 40), 35);
    chk("model 1000", requant(1, 1000), 255);
    chk("model 100 default", requant(0, 100), 100);

    repeat (3) @(negedge clk);
    chk("reset out_valid", vld0, 0);
    chk("reset fifo_count", c0, 0);
    chk("reset overflow", ovf1, 0);
    chk("reset out_value", v1, 0);
    rst = 1'b0;

    // Basic ordering and scaling.
    out_ready = 1'b1;
    directed4(lit_in0, lit_in0, lit_d1a);
    directed4(lit_in1, lit_d0b, lit_d1b);

    // Gaps: invalid words with nonzero data interleaved with 9 valid results.
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      input_result = (k % 2 == 0) ? {1'b1, 16'(k * 37)} : {1'b0, 16'hA5A5};
    end
    @(negedge clk); input_result = '0;
    repeat (6) @(negedge clk);

    // Overflow: 10 results into a stalled FIFO.
    reset_pulse();
    out_ready = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      input_result = (k < 10) ? {1'b1, 16'(k + 1)} : 17'd0;
    end
    @(negedge clk);
    chk("ovf count", c0, 8);
    chk("ovf flag", ovf0, 1);
    out_ready = 1'b1;
    chk("drain idx 0", i0, 0);
    for (int j = 1; j < 8; j++) begin
      @(negedge clk);
      chk("drain idx", i0, j % 4);
    end
    @(negedge clk);
    chk("drained valid", vld0, 0);
    chk("ovf sticky", ovf0, 1);

    // Full FIFO with a pop on the same edge as a write.
    reset_pulse();
    out_ready = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      input_result = (k < 9) ? {1'b1, 16'(k * 11)} : 17'd0;
      out_ready = (k == 10);
      if (k == 11) begin
        chk("fullpop count", c0, 8);
        chk("fullpop ovf", ovf0, 0);
        chk("fullpop head", i0, 1);
      end
    end
    out_ready = 1'b1;
    repeat (10) @(negedge clk);

    // Asynchronous reset with 3 buffered and 2 in flight.
    reset_pulse();
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      input_result = {1'b1, 16'(k + 1)};
    end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async out_valid", vld0, 0);
    chk("async fifo_count", c1, 0);
    input_result = '0;
    @(negedge clk); rst = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      input_result = (k == 0) ? {1'b1, 16'd50} : 17'd0;
      if (k == 1 || k == 2) chk("post-reset empty", vld0, 0);
      if (k == 3) begin
        chk("post-reset valid", vld0, 1);
        chk("post-reset index", i0, 0);
        chk("post-reset value", v0, 50);
        chk("post-reset count", c0, 1);
      end
    end

    // Randomized traffic with alternating drain pressure.
    reset_pulse();
    for (int k = 0; k < 800; k++) begin
      @(negedge clk);
      input_result = {($urandom_range(0, 3) != 0), 16'($urandom)};
      if ($urandom_range(0, 3) == 0) input_result[15:0] = 16'($urandom_range(0, 300));
      out_ready = ((k / 50) % 2 == 0) ? ($urandom_range(0, 9) < 2) : ($urandom_range(0, 9) < 9);
    end
    input_result = '0;
    out_ready = 1'b1;
    repeat (15) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
